vga_timing_gen: RTL and testbench

- Generates the VGA raster that drives the pixel coordinates x, y, consumed by the text/bitmap overlay lookups and the colour mux.
- Produces the pixel counters, hsync, vsync, a display-active flag, line and frame strobes, and a frame counter for animation.
- Default timing is 640x480@60 Hz with a 25.175 MHz pixel clock; one clk edge equals one pixel.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_timing_gen_if.sv | 24 ++
 rtl/vga_axis_counter.sv | 57 +++++
 rtl/vga_timing_gen.sv | 87 ++++++++
 tb/tb_vga_timing_gen.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared defaults for the 640x480@60 raster and the per-axis phase encoding.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  function automatic int unsigned axis_total(input int unsigned d, input int unsigned f,
                                             input int unsigned s, input int unsigned b);
    return d + f + s + b;
  endfunction

  localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus: enable in, coordinates and timing decodes out.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic             ena;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             hsync;
  logic             vsync;
  logic             display_on;
  logic             line_start;
  logic             frame_start;
  logic [7:0]       frame_count;

  modport master (
    input  ena,
    output x, y, hsync, vsync, display_on, line_start, frame_start, frame_count
  );

  modport slave (
    output ena,
    input  x, y, hsync, vsync, display_on, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus its ACTIVE/FRONT/SYNC/BACK phase FSM.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned FRONT   = DEF_H_FRONT,
  parameter int unsigned SYNC    = DEF_H_SYNC,
  parameter int unsigned BACK    = DEF_H_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt,
  output phase_t           phase_nxt,
  output logic             wrap
);

  localparam int unsigned      TOTAL   = axis_total(DISPLAY, FRONT, SYNC, BACK);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] C_FRONT = CNT_W'(DISPLAY);
  localparam logic [CNT_W-1:0] C_SYNC  = CNT_W'(DISPLAY + FRONT);
  localparam logic [CNT_W-1:0] C_BACK  = CNT_W'(DISPLAY + FRONT + SYNC);

  logic [CNT_W-1:0] r_count;
  phase_t           r_phase;
  logic [CNT_W-1:0] w_adv;
  phase_t           w_phase_adv;

  // Next values are exported so the top can register decodes of the new position.
  always_comb begin
    w_adv       = (r_count == C_LAST) ? '0 : r_count + 1'b1;
    w_phase_adv = r_phase;
    unique case (r_phase)
      PH_ACTIVE: if (w_adv == C_FRONT) w_phase_adv = PH_FRONT;
      PH_FRONT:  if (w_adv == C_SYNC)  w_phase_adv = PH_SYNC;
      PH_SYNC:   if (w_adv == C_BACK)  w_phase_adv = PH_BACK;
      PH_BACK:   if (w_adv == '0)      w_phase_adv = PH_ACTIVE;
    endcase
    count_nxt = step ? w_adv : r_count;
    phase_nxt = step ? w_phase_adv : r_phase;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= C_LAST;
      r_phase <= PH_BACK;
    end else begin
      r_count <= count_nxt;
      r_phase <= phase_nxt;
    end
  end

  assign count = r_count;
  assign wrap  = step && (r_count == C_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: two axis counters plus registered sync, blanking, strobes and frame count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY   = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_DISPLAY   = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master bus
);

  logic [CNT_W-1:0] w_h_count, w_h_count_nxt;
  logic [CNT_W-1:0] w_v_count, w_v_count_nxt;
  phase_t           w_h_phase_nxt, w_v_phase_nxt;
  logic             w_h_wrap, w_v_wrap;

  logic             r_hsync, r_vsync, r_display_on;
  logic             r_line_start, r_frame_start;
  logic [7:0]       r_frame_count;

  vga_axis_counter #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (bus.ena),
    .count     (w_h_count),
    .count_nxt (w_h_count_nxt),
    .phase_nxt (w_h_phase_nxt),
    .wrap      (w_h_wrap)
  );

  // The horizontal wrap already carries ena, so the vertical axis steps once per line.
  vga_axis_counter #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (w_h_wrap),
    .count     (w_v_count),
    .count_nxt (w_v_count_nxt),
    .phase_nxt (w_v_phase_nxt),
    .wrap      (w_v_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync       <= ~SYNC_ACTIVE;
      r_vsync       <= ~SYNC_ACTIVE;
      r_display_on  <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '1;
    end else begin
      r_hsync       <= (w_h_phase_nxt == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync       <= (w_v_phase_nxt == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_display_on  <= (w_h_phase_nxt == PH_ACTIVE) && (w_v_phase_nxt == PH_ACTIVE);
      r_line_start  <= bus.ena && (w_h_count_nxt == '0);
      r_frame_start <= bus.ena && (w_h_count_nxt == '0) && (w_v_count_nxt == '0);
      if (w_v_wrap) r_frame_count <= r_frame_count + 1'b1;
    end
  end

  assign bus.x           = w_h_count;
  assign bus.y           = w_v_count;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.display_on  = r_display_on;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a small-timing instance checked per cycle against a coordinate model, plus one default-timing line.
module tb_vga_timing_gen;

  localparam int unsigned HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VD = 6, VF = 1, VS = 2, VB = 1;
  localparam int unsigned HT = HD + HF + HS + HB;
  localparam int unsigned VT = VD + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       disp;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  typedef struct {
    string       name;
    logic        ena;
    int unsigned n;
    out_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_timing_gen_if sif ();
  vga_timing_gen_if dif ();

  vga_timing_gen #(
    .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .SYNC_ACTIVE (1'b0)
  ) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.master)
  );

  vga_timing_gen dut_dflt (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.master)
  );

  int   checks = 0;
  int   errors = 0;
  int   mx, my;
  logic [7:0] mfc;
  out_t sb_q[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic out_t sample();
    return '{sif.x, sif.y, sif.hsync, sif.vsync, sif.display_on,
             sif.line_start, sif.frame_start, sif.frame_count};
  endfunction

  function automatic out_t mk_out(int x, int y, logic hs, logic vs, logic d,
                                  logic ls, logic fs, logic [7:0] fc);
    return '{10'(x), 10'(y), hs, vs, d, ls, fs, fc};
  endfunction

  function automatic vec_t mk(string name, logic e, int unsigned n, out_t o);
    vec_t v;
    v.name = name; v.ena = e; v.n = n; v.exp = o;
    return v;
  endfunction

  task automatic model_reset();
    mx = HT - 1; my = VT - 1; mfc = 8'hFF;
    sb_q.delete();
  endtask

  function automatic out_t model_out(input logic e);
    out_t o;
    o.x    = 10'(mx);
    o.y    = 10'(my);
    o.hs   = !(mx >= int'(HD + HF) && mx < int'(HD + HF + HS));
    o.vs   = !(my >= int'(VD + VF) && my < int'(VD + VF + VS));
    o.disp = (mx < int'(HD)) && (my < int'(VD));
    o.ls   = e && (mx == 0);
    o.fs   = e && (mx == 0) && (my == 0);
    o.fc   = mfc;
    return o;
  endfunction

  task automatic step(input logic e);
    out_t got, ex;
    @(negedge clk);
    sif.ena = e;
    if (e) begin
      mx++;
      if (mx == int'(HT)) begin
        mx = 0;
        my++;
        if (my == int'(VT)) my = 0;
      end
      if (mx == 0 && my == 0) mfc++;
    end
    sb_q.push_back(model_out(e));
    @(posedge clk);
    #1;
    got = sample();
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 64'(1), 64'(0));
    end else begin
      ex = sb_q.pop_front();
      chk("sb", 64'(got), 64'(ex));
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    out_t rst_exp;
    int   hs_low;
    rst_exp = mk_out(HT - 1, VT - 1, 1, 1, 0, 0, 0, 8'hFF);

    vecs.push_back(mk("v_first",    1, 1,   mk_out(0,  0, 1, 1, 1, 1, 1, 8'd0)));
    vecs.push_back(mk("v_hsync",    1, 10,  mk_out(10, 0, 0, 1, 0, 0, 0, 8'd0)));
    vecs.push_back(mk("v_hold",     0, 5,   mk_out(10, 0, 0, 1, 0, 0, 0, 8'd0)));
    vecs.push_back(mk("v_line1",    1, 5,   mk_out(0,  1, 1, 1, 1, 1, 0, 8'd0)));
    vecs.push_back(mk("v_lastvis",  1, 7,   mk_out(7,  1, 1, 1, 1, 0, 0, 8'd0)));
    vecs.push_back(mk("v_hblank",   1, 1,   mk_out(8,  1, 1, 1, 0, 0, 0, 8'd0)));
    vecs.push_back(mk("v_vsync",    1, 82,  mk_out(0,  7, 1, 0, 0, 1, 0, 8'd0)));
    vecs.push_back(mk("v_hvsync",   1, 12,  mk_out(12, 7, 0, 0, 0, 0, 0, 8'd0)));
    vecs.push_back(mk("v_hold2",    0, 3,   mk_out(12, 7, 0, 0, 0, 0, 0, 8'd0)));
    vecs.push_back(mk("v_hsync_end",1, 1,   mk_out(13, 7, 1, 0, 0, 0, 0, 8'd0)));
    vecs.push_back(mk("v_frame1",   1, 32,  mk_out(0,  0, 1, 1, 1, 1, 1, 8'd1)));
    vecs.push_back(mk("v_lastpix",  1, 149, mk_out(14, 9, 1, 1, 0, 0, 0, 8'd1)));
    vecs.push_back(mk("v_frame2",   1, 1,   mk_out(0,  0, 1, 1, 1, 1, 1, 8'd2)));

    rst_n   = 1'b0;
    sif.ena = 1'b0;
    dif.ena = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_small", 64'(sample()), 64'(rst_exp));
    chk("rst_dflt_x", 64'(dif.x), 64'(799));
    chk("rst_dflt_y", 64'(dif.y), 64'(524));
    chk("rst_dflt_hs", 64'(dif.hsync), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Default 640x480 timing: one full line, then the start of the next.
    @(negedge clk);
    dif.ena = 1'b1;
    hs_low = 0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      chk("dflt_x", 64'(dif.x), 64'(i));
      chk("dflt_y", 64'(dif.y), 64'(0));
      chk("dflt_hs", 64'(dif.hsync), 64'(!(i >= 656 && i <= 751)));
      chk("dflt_disp", 64'(dif.display_on), 64'(i < 640));
      chk("dflt_ls", 64'(dif.line_start), 64'(i == 0));
      if (!dif.hsync) hs_low++;
    end
    chk("dflt_hs_width", 64'(hs_low), 64'(96));
    @(posedge clk);
    #1;
    chk("dflt_wrap_x", 64'(dif.x), 64'(0));
    chk("dflt_wrap_y", 64'(dif.y), 64'(1));
    chk("dflt_wrap_ls", 64'(dif.line_start), 64'(1));
    chk("dflt_wrap_fs", 64'(dif.frame_start), 64'(0));
    chk("dflt_fc", 64'(dif.frame_count), 64'(0));
    @(negedge clk);
    dif.ena = 1'b0;

    foreach (vecs[k]) begin
      for (int unsigned c = 0; c < vecs[k].n; c++) step(vecs[k].ena);
      chk(vecs[k].name, 64'(sample()), 64'(vecs[k].exp));
    end

    // Asynchronous reset in the middle of both sync pulses, away from any clock edge.
    repeat (116) step(1'b1);
    chk("pre_rst_x", 64'(sif.x), 64'(11));
    chk("pre_rst_syncs", 64'({sif.hsync, sif.vsync}), 64'(2'b00));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 64'(sample()), 64'(rst_exp));
    sif.ena = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // frame_count wrap 255 -> 0 on entering (0,0).
    repeat (1 + 255 * FRAME) step(1'b1);
    chk("fc_255", 64'(sif.frame_count), 64'(255));
    chk("fc_255_fs", 64'(sif.frame_start), 64'(1));
    repeat (FRAME - 1) step(1'b1);
    chk("fc_pre_wrap", 64'(sif.frame_count), 64'(255));
    step(1'b1);
    chk("fc_wrap", 64'(sif.frame_count), 64'(0));
    chk("fc_wrap_fs", 64'(sif.frame_start), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
